key_expansion_seq: RTL
======================

Name: key_expansion_seq

Overview:
- Sequential, runtime-selectable AES key schedule covering AES-128, AES-192 and AES-256.
- Expands one 32-bit word per clock into an internal round-key store. Replaces the fully combinational expander, so the S-box cost is 4 lookups instead of one per word.
- Sits between key load logic and the round datapath. The cipher core fetches round keys through a registered read port.

Parameters:
- NK_MAX, 8, largest supported key length in 32-bit words. Legal values are 4, 6 and 8. Store depth is 4*(NK_MAX+7) words.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to expand key. Sampled only while busy=0.
- key_size  in  2  key length select: 00=128, 01=192, 10=256, 11=illegal.
- key  in  256  cipher key, MSB-aligned. Word 0 is key[255:224]. Unused LSBs are ignored.
- busy  out  1  high while expansion is in progress.
- done  out  1  one-cycle pulse when the schedule is complete.
- keys_valid  out  1  the store holds a complete schedule.
- num_rounds  out  4  Nr of the latched key size: 10, 12 or 14.
- rk_rd_en  in  1  round-key read strobe.
- rk_rd_round  in  4  round index to read.
- rk_rd_data  out  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, first word in the MSBs.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, keys_valid=0, num_rounds=0, rk_rd_data=0. Rcon register=0x01. Store contents are don't-care. A reset mid-expansion aborts it immediately.
- Start acceptance: start accepted only if busy=0 and key_size is legal and Nk<=NK_MAX. Otherwise start is ignored with no state change. This includes start while busy.
- On acceptance:
  - latch key_size.
  - Nk = 4, 6 or 8; Nr = Nk+6.
  - num_rounds=Nr.
  - keys_valid cleared.
- FSM IDLE -> LOAD -> EXPAND -> DONE -> IDLE. busy=1 in LOAD, EXPAND and DONE.
- Cycle numbering: the start edge is cycle 0.
- LOAD (cycle 1):
  - write w[0..Nk-1] from key.
  - set word index i=Nk and phase counter p=0 (p = i mod Nk, maintained by counter, no divider).
  - rcon=0x01.
- EXPAND: one word per cycle, word i written in cycle 2+(i-Nk).
  - temp = w[i-1].
  - If p==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon = xtime(rcon). xtime: shift left; if the MSB was 1, XOR with 0x1b.
  - Else if Nk==8 and p==4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp.
  - i and p increment; p wraps at Nk.
  - The cycle writing the last word, i = 4*(Nr+1)-1, moves the FSM to DONE.
- Word counts and done timing:
  - 40, 46 and 52 expansion cycles for 128, 192 and 256.
  - done pulses at cycle 42, 48 and 54 respectively.
- DONE (1 cycle): done=1, keys_valid=1, then IDLE. A start in the DONE cycle is ignored; start is accepted from the next cycle.
- Read port:
  - on rk_rd_en, rk_rd_data updates on the next edge (1-cycle latency); otherwise it holds.
  - Returns 0 if keys_valid=0 or rk_rd_round>Nr.
  - Reads are legal at any time; during busy they return 0.
- S-box: 4 instances only, in the word-generation path. Contents per FIPS-197.

Test Plan:
- AES-128: key=2b7e151628aed2a6abf7158809cf4f3c, key_size=00.
  - done at cycle 42, num_rounds=10.
  - read round 1 -> a0fafe1788542cb123a339392a6c7605.
  - read round 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192: key=8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, key_size=01.
  - done at cycle 48, num_rounds=12.
  - read round 12 -> e98ba06f448c773c8ecc720401002202.
- AES-256: key=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, key_size=10.
  - done at cycle 54.
  - read round 14 -> fe4890d1e6188d0b046df344706c631e.
- Illegal and ignored requests:
  - start with key_size=11 -> busy stays 0, no done.
  - start during busy -> ignored; the original schedule completes unchanged.
  - with NK_MAX=4, a start with key_size=10 is ignored.
- Reset mid-run: rst at cycle 20 of an AES-256 run -> busy=0 and keys_valid=0 next cycle; round-0 read returns 0. A fresh AES-128 start then completes correctly.
- Read boundaries after AES-128:
  - rk_rd_round=11 -> 0.
  - back-to-back reads of rounds 0..10 -> one key per cycle, 1-cycle latency.
  - round 0 -> the key itself.

Source files
------------

// File: rtl/key_expansion_seq.sv
// Sequential AES key schedule for AES-128/192/256.
// Generates one 32-bit schedule word per clock into an internal round-key
// store using a single 4-byte S-box slice. Round keys are fetched through a
// registered read port with one cycle of latency.
module key_expansion_seq #(
    parameter int NK_MAX = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_size,
    input  logic [255:0] key,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    output logic [3:0]   num_rounds,
    input  logic         rk_rd_en,
    input  logic [3:0]   rk_rd_round,
    output logic [127:0] rk_rd_data
);

    localparam int         DEPTH    = 4 * (NK_MAX + 7);
    localparam int         IW       = 6;
    localparam logic [3:0] NK_MAX_W = 4'(NK_MAX);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_EXPAND = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // FIPS-197 S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        sbox = SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        sub_word = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t          state_q, state_d;
    logic [255:0]    key_q, key_d;
    logic [3:0]      nk_q, nk_d;
    logic [3:0]      nr_q, nr_d;
    logic [IW-1:0]   i_q, i_d;
    logic [2:0]      p_q, p_d;
    logic [7:0]      rcon_q, rcon_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            keys_valid_q, keys_valid_d;
    logic [127:0]    rd_data_q, rd_data_d;
    logic [31:0]     w_q [DEPTH];

    logic [3:0]      nk_sel_s;
    logic            start_ok_s;
    logic [IW-1:0]   last_idx_s;
    logic [31:0]     prev_w_s;
    logic [31:0]     old_w_s;
    logic [31:0]     sub_out_s;
    logic [31:0]     temp_s;
    logic [31:0]     new_w_s;
    logic [IW-1:0]   rd_base_s;

    // Decode the requested key length and decide whether start is accepted.
    always_comb begin
        case (key_size)
            2'b00:   nk_sel_s = 4'd4;
            2'b01:   nk_sel_s = 4'd6;
            2'b10:   nk_sel_s = 4'd8;
            default: nk_sel_s = 4'd0;
        endcase
        start_ok_s = start && (state_q == S_IDLE) && (nk_sel_s != 4'd0) && (nk_sel_s <= NK_MAX_W);
        last_idx_s = {nr_q, 2'b00} + 6'd3;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok_s) state_d = S_LOAD;
                else            state_d = S_IDLE;
            end
            S_LOAD:   state_d = S_EXPAND;
            S_EXPAND: begin
                if (i_q == last_idx_s) state_d = S_DONE;
                else                   state_d = S_EXPAND;
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Word generator: the only S-box slice, shared by RotWord and Nk=8 paths.
    always_comb begin
        prev_w_s  = w_q[i_q - 6'd1];
        old_w_s   = w_q[i_q - {2'b00, nk_q}];
        sub_out_s = sub_word((p_q == 3'd0) ? {prev_w_s[23:0], prev_w_s[31:24]} : prev_w_s);
        if (p_q == 3'd0) begin
            temp_s = sub_out_s ^ {rcon_q, 24'h000000};
        end else if ((nk_q == 4'd8) && (p_q == 3'd4)) begin
            temp_s = sub_out_s;
        end else begin
            temp_s = prev_w_s;
        end
        new_w_s = old_w_s ^ temp_s;
    end

    // Key latch, word index, phase counter and round constant update.
    always_comb begin
        key_d  = key_q;
        nk_d   = nk_q;
        nr_d   = nr_q;
        i_d    = i_q;
        p_d    = p_q;
        rcon_d = rcon_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok_s) begin
                    key_d = key;
                    nk_d  = nk_sel_s;
                    nr_d  = nk_sel_s + 4'd6;
                end else begin
                    key_d = key_q;
                end
            end
            S_LOAD: begin
                i_d    = {2'b00, nk_q};
                p_d    = 3'd0;
                rcon_d = 8'h01;
            end
            S_EXPAND: begin
                i_d = i_q + 6'd1;
                if ({1'b0, p_q} == (nk_q - 4'd1)) p_d = 3'd0;
                else                              p_d = p_q + 3'd1;
                if (p_q == 3'd0) rcon_d = xtime(rcon_q);
                else             rcon_d = rcon_q;
            end
            default: begin
                i_d = i_q;
            end
        endcase
    end

    // FSM output logic; status flags are registered from the next state.
    always_comb begin
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        if (state_d == S_LOAD) begin
            keys_valid_d = 1'b0;
        end else if (state_d == S_DONE) begin
            keys_valid_d = 1'b1;
        end else begin
            keys_valid_d = keys_valid_q;
        end
    end

    // Read port: out-of-range rounds and an incomplete schedule read as zero.
    always_comb begin
        rd_base_s = {rk_rd_round, 2'b00};
        rd_data_d = rd_data_q;
        if (rk_rd_en) begin
            if (keys_valid_q && (rk_rd_round <= nr_q)) begin
                rd_data_d = {w_q[rd_base_s], w_q[rd_base_s + 6'd1],
                             w_q[rd_base_s + 6'd2], w_q[rd_base_s + 6'd3]};
            end else begin
                rd_data_d = 128'd0;
            end
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // State register and control/output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            key_q        <= 256'd0;
            nk_q         <= 4'd0;
            nr_q         <= 4'd0;
            i_q          <= 6'd0;
            p_q          <= 3'd0;
            rcon_q       <= 8'h01;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            keys_valid_q <= 1'b0;
            rd_data_q    <= 128'd0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            nk_q         <= nk_d;
            nr_q         <= nr_d;
            i_q          <= i_d;
            p_q          <= p_d;
            rcon_q       <= rcon_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            keys_valid_q <= keys_valid_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Round-key store: key words in LOAD, one generated word per EXPAND cycle.
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD) begin
            for (int k = 0; k < NK_MAX; k++) begin
                if (4'(k) < nk_q) w_q[IW'(k)] <= key_q[255 - 32*k -: 32];
            end
        end else if (state_q == S_EXPAND) begin
            w_q[i_q] <= new_w_s;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign keys_valid = keys_valid_q;
    assign num_rounds = nr_q;
    assign rk_rd_data = rd_data_q;

endmodule
